// File: rtl/snake_pkg.sv
// Shared Snake board types and constants.
// Cell index layout is {row[2:0], col[2:0]}.
package snake_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;
  localparam int CELL_W    = 6;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SCAN
  } food_state_e;

endpackage

// File: rtl/occ_lookup.sv
// Occupancy probe: selects occ[idx] and flags a full board.
// Shared with the collision checker.
module occ_lookup
  import snake_pkg::*;
(
  input  logic [63:0] occ,
  input  cell_t       idx,
  output logic        hit,
  output logic        full
);

  // Pure combinational select and reduction.
  always_comb begin
    hit  = occ[idx];
    full = &occ;
  end

endmodule

// File: rtl/food_spawner.sv
// Picks a free cell for food from the LFSR sample stream.
// FOOD_SCAN_FALLBACK_EN adds a bounded linear-scan fallback.
module food_spawner
  import snake_pkg::*;
#(
  parameter int MAX_TRIES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  rnd,
  input  logic [63:0] occ,
  input  logic        spawn_req,
  input  logic        clear_food,
  output logic [2:0]  food_row,
  output logic [2:0]  food_col,
  output logic        food_valid,
  output logic        spawn_done,
  output logic        board_full,
  output logic        busy
);

  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_tries
    $error("MAX_TRIES out of range 1..15");
  end

  food_state_e state;
  cell_t       cand;
  logic        hit;
  logic        full;

`ifdef FOOD_SCAN_FALLBACK_EN
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);
  logic [3:0] tries;
`endif

  occ_lookup u_occ (
    .occ  (occ),
    .idx  (cand),
    .hit  (hit),
    .full (full)
  );

  assign busy = (state != S_IDLE);

  // Spawn FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cand       <= '0;
`ifdef FOOD_SCAN_FALLBACK_EN
      tries      <= '0;
`endif
      food_row   <= '0;
      food_col   <= '0;
      food_valid <= 1'b0;
      spawn_done <= 1'b0;
      board_full <= 1'b0;
    end else begin
      spawn_done <= 1'b0;
      if (clear_food) food_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (spawn_req) begin
            if (full) begin
              board_full <= 1'b1;
            end else begin
              cand  <= rnd;
`ifdef FOOD_SCAN_FALLBACK_EN
              tries <= '0;
`endif
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (!hit) begin
            food_row   <= cand[5:3];
            food_col   <= cand[2:0];
            food_valid <= 1'b1;
            spawn_done <= 1'b1;
            board_full <= 1'b0;
            state      <= S_IDLE;
          end else begin
`ifdef FOOD_SCAN_FALLBACK_EN
            tries <= tries + 4'd1;
            if (tries == LAST_TRY) begin
              cand  <= cand + 6'd1;
              state <= S_SCAN;
            end else begin
              cand <= rnd;
            end
`else
            cand <= rnd;
`endif
          end
        end
        S_SCAN: begin
          if (!hit) begin
            food_row   <= cand[5:3];
            food_col   <= cand[2:0];
            food_valid <= 1'b1;
            spawn_done <= 1'b1;
            board_full <= 1'b0;
            state      <= S_IDLE;
          end else begin
            cand <= cand + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner.
// Scan scenarios run only with FOOD_SCAN_FALLBACK_EN.
module tb_food_spawner;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  rnd;
  logic [63:0] occ;
  logic        spawn_req;
  logic        clear_food;
  logic [2:0]  food_row;
  logic [2:0]  food_col;
  logic        food_valid;
  logic        spawn_done;
  logic        board_full;
  logic        busy;

  int checks = 0;
  int errors = 0;

  food_spawner #(.MAX_TRIES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rnd        (rnd),
    .occ        (occ),
    .spawn_req  (spawn_req),
    .clear_food (clear_food),
    .food_row   (food_row),
    .food_col   (food_col),
    .food_valid (food_valid),
    .spawn_done (spawn_done),
    .board_full (board_full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    rnd        = 6'h00;
    occ        = '0;
    spawn_req  = 1'b0;
    clear_food = 1'b0;
    #3;
    checks++;
    if ({food_row, food_col, food_valid, spawn_done, board_full, busy}
        !== 10'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 0",
        {food_row, food_col, food_valid, spawn_done, board_full, busy});
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_empty;
    occ = '0;
    rnd = 6'h2A;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    rnd = 6'h01;
    checks++;
    if (busy !== 1'b1 || spawn_done !== 1'b0) begin
      errors++;
      $display("FAIL empty_busy got busy=%b done=%b want 1 0",
        busy, spawn_done);
    end
    tick();
    checks++;
    if ({spawn_done, food_valid, food_row, food_col, busy}
        !== {1'b1, 1'b1, 3'd5, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL empty_accept got d=%b v=%b r=%0d c=%0d b=%b want 1 1 5 2 0",
        spawn_done, food_valid, food_row, food_col, busy);
    end
    tick();
    checks++;
    if (spawn_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got %b want 0", spawn_done);
    end
  endtask

  task automatic test_resample;
    logic [3:0] bz;
    occ = '0;
    occ[6'h2A] = 1'b1;
    rnd = 6'h2A;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    bz[0] = busy;
    rnd = 6'h2A;
    tick();
    bz[1] = busy;
    rnd = 6'h11;
    tick();
    bz[2] = busy;
    checks++;
    if (spawn_done !== 1'b0) begin
      errors++;
      $display("FAIL resample_early got done=%b want 0", spawn_done);
    end
    rnd = 6'h05;
    tick();
    bz[3] = busy;
    checks++;
    if (bz !== 4'b0111) begin
      errors++;
      $display("FAIL resample_busy got %b want 0111", bz);
    end
    checks++;
    if ({spawn_done, food_valid, food_row, food_col}
        !== {1'b1, 1'b1, 3'd2, 3'd1}) begin
      errors++;
      $display("FAIL resample_accept got d=%b v=%b r=%0d c=%0d want 1 1 2 1",
        spawn_done, food_valid, food_row, food_col);
    end
  endtask

  task automatic test_full;
    bit seen;
    occ = '1;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    checks++;
    if ({board_full, spawn_done, busy, food_valid, food_row, food_col}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 3'd1}) begin
      errors++;
      $display("FAIL full_flag got f=%b d=%b b=%b v=%b r=%0d c=%0d want 1 0 0 1 2 1",
        board_full, spawn_done, busy, food_valid, food_row, food_col);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (spawn_done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || board_full !== 1'b1) begin
      errors++;
      $display("FAIL full_sticky got done_seen=%b full=%b want 0 1",
        seen, board_full);
    end
  endtask

  task automatic test_clear;
    clear_food = 1'b1;
    tick();
    clear_food = 1'b0;
    checks++;
    if (food_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear got %b want 0", food_valid);
    end
    occ = '0;
    rnd = 6'h05;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    clear_food = 1'b1;
    tick();
    clear_food = 1'b0;
    checks++;
    if ({food_valid, spawn_done, board_full, food_row, food_col}
        !== {1'b1, 1'b1, 1'b0, 3'd0, 3'd5}) begin
      errors++;
      $display("FAIL clear_vs_accept got v=%b d=%b f=%b r=%0d c=%0d want 1 1 0 0 5",
        food_valid, spawn_done, board_full, food_row, food_col);
    end
  endtask

`ifdef FOOD_SCAN_FALLBACK_EN
  task automatic test_scan(input int free_cell, input int want_lat);
    int lat;
    occ = '1;
    occ[free_cell] = 1'b0;
    rnd = 6'h10;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    lat = 0;
    while (!spawn_done && lat < 100) begin
      spawn_req = (lat == 10);
      tick();
      lat++;
    end
    spawn_req = 1'b0;
    checks++;
    if (lat !== want_lat) begin
      errors++;
      $display("FAIL scan_latency cell=%0d got %0d want %0d",
        free_cell, lat, want_lat);
    end
    checks++;
    if ({food_row, food_col} !== 6'(free_cell) || food_valid !== 1'b1) begin
      errors++;
      $display("FAIL scan_cell got %0d v=%b want %0d 1",
        {food_row, food_col}, food_valid, free_cell);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || spawn_done !== 1'b0) begin
      errors++;
      $display("FAIL scan_no_queue got busy=%b done=%b want 0 0",
        busy, spawn_done);
    end
  endtask
`endif

  task automatic test_reset_mid;
    occ = '1;
    occ[63] = 1'b0;
    rnd = 6'h10;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({food_row, food_col, food_valid, spawn_done, board_full, busy}
        !== 10'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 0",
        {food_row, food_col, food_valid, spawn_done, board_full, busy});
    end
    tick();
    reset = 1'b1;
    occ = '0;
    rnd = 6'h07;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    tick();
    checks++;
    if ({spawn_done, food_valid, food_row, food_col}
        !== {1'b1, 1'b1, 3'd0, 3'd7}) begin
      errors++;
      $display("FAIL post_reset got d=%b v=%b r=%0d c=%0d want 1 1 0 7",
        spawn_done, food_valid, food_row, food_col);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_resample();
    test_full();
    test_clear();
`ifdef FOOD_SCAN_FALLBACK_EN
    test_scan(63, 51);
    test_scan(0, 52);
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
